// File: rtl/escalonador_semaforo.sv
// Round-robin green-phase scheduler for a 4-approach intersection with a latched pedestrian phase.
// Optional feature macro: GREEN_EXTEND_EN (green extension while the served approach keeps requesting).
module escalonador_semaforo #(
    parameter logic [7:0] T_VERDE_RST    = 8'd4,
    parameter logic [7:0] T_AMARELO_RST  = 8'd2,
    parameter logic [7:0] T_VERMELHO_RST = 8'd1,
    parameter logic [7:0] T_PEDESTRE_RST = 8'd3
`ifdef GREEN_EXTEND_EN
    ,
    parameter int MAX_EXT = 2
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic        bt,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    output logic [11:0] luz,
    output logic        ped_luz,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, GREEN, YELLOW, PED, ALL_RED} state_t;

    localparam logic [2:0] L_VERDE    = 3'b001;
    localparam logic [2:0] L_AMARELO  = 3'b010;
    localparam logic [2:0] L_VERMELHO = 3'b100;

    state_t      state_reg, state_next;
    logic [7:0]  timer_reg, timer_next;
    logic [1:0]  grant_reg, grant_next;
    logic [3:0]  pend_reg, pend_next, pend_clr;
    logic        ped_pend_reg, ped_pend_next, ped_clr;
    logic [11:0] luz_reg, luz_next;
    logic        ped_luz_reg, busy_reg;
    logic [1:0]  sel;
    logic        extend;
    logic [7:0]  cfg_reg [4];

    // A programmed duration of 0 behaves as 1 cycle.
    function automatic logic [7:0] load_val(input logic [7:0] d);
        return (d == 8'd0) ? 8'd0 : d - 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_reg[0] <= T_VERDE_RST;
            cfg_reg[1] <= T_AMARELO_RST;
            cfg_reg[2] <= T_VERMELHO_RST;
            cfg_reg[3] <= T_PEDESTRE_RST;
        end else if (cfg_we) begin
            cfg_reg[cfg_addr] <= cfg_data;
        end
    end

    // First pending approach after the last granted one, wrapping around.
    always_comb begin
        sel = grant_reg;
        for (int k = 4; k >= 1; k--) begin
            if (pend_reg[grant_reg + 2'(k)]) begin
                sel = grant_reg + 2'(k);
            end
        end
    end

`ifdef GREEN_EXTEND_EN
    logic [1:0] ext_cnt_reg, ext_cnt_next;

    assign extend = req[grant_reg]
                 && ((pend_reg & ~(4'b0001 << grant_reg)) == 4'b0000)
                 && !ped_pend_reg
                 && (ext_cnt_reg < 2'(MAX_EXT));

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_cnt_reg <= 2'd0;
        end else begin
            ext_cnt_reg <= ext_cnt_next;
        end
    end
`else
    assign extend = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        grant_next = grant_reg;
        pend_clr   = 4'b0000;
        ped_clr    = 1'b0;
`ifdef GREEN_EXTEND_EN
        ext_cnt_next = ext_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (ped_pend_reg) begin
                    state_next = PED;
                    timer_next = load_val(cfg_reg[3]);
                    ped_clr    = 1'b1;
                end else if (pend_reg != 4'b0000) begin
                    state_next = GREEN;
                    grant_next = sel;
                    timer_next = load_val(cfg_reg[0]);
                    pend_clr   = 4'b0001 << sel;
`ifdef GREEN_EXTEND_EN
                    ext_cnt_next = 2'd0;
`endif
                end
            end
            GREEN: begin
                if (timer_reg != 8'd0) begin
                    timer_next = timer_reg - 8'd1;
                end else if (extend) begin
                    timer_next = load_val(cfg_reg[0]);
`ifdef GREEN_EXTEND_EN
                    ext_cnt_next = ext_cnt_reg + 2'd1;
`endif
                end else begin
                    state_next = YELLOW;
                    timer_next = load_val(cfg_reg[1]);
                end
            end
            YELLOW, PED: begin
                if (timer_reg != 8'd0) begin
                    timer_next = timer_reg - 8'd1;
                end else begin
                    state_next = ALL_RED;
                    timer_next = load_val(cfg_reg[2]);
                end
            end
            ALL_RED: begin
                if (timer_reg != 8'd0) begin
                    timer_next = timer_reg - 8'd1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A new request wins over the clear at green entry; the button is ignored during the walk.
    assign pend_next     = (pend_reg & ~pend_clr) | req;
    assign ped_pend_next = ped_clr ? 1'b0
                         : (state_reg == PED) ? ped_pend_reg
                         : (ped_pend_reg | bt);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_luz
            assign luz_next[3*gi +: 3] =
                (state_next == GREEN  && grant_next == 2'(gi)) ? L_VERDE :
                (state_next == YELLOW && grant_next == 2'(gi)) ? L_AMARELO :
                L_VERMELHO;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            timer_reg    <= 8'd0;
            grant_reg    <= 2'd3;
            pend_reg     <= 4'b0000;
            ped_pend_reg <= 1'b0;
            luz_reg      <= {4{L_VERMELHO}};
            ped_luz_reg  <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            grant_reg    <= grant_next;
            pend_reg     <= pend_next;
            ped_pend_reg <= ped_pend_next;
            luz_reg      <= luz_next;
            ped_luz_reg  <= (state_next == PED);
            busy_reg     <= (state_next != IDLE);
        end
    end

    assign luz     = luz_reg;
    assign ped_luz = ped_luz_reg;
    assign grant   = grant_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_escalonador_semaforo.sv
// Directed bench for escalonador_semaforo: a phase-queue model checked every cycle plus literal light patterns.
module tb_escalonador_semaforo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic        bt = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [7:0]  cfg_data = 8'd0;
    logic [11:0] luz;
    logic        ped_luz;
    logic [1:0]  grant;
    logic        busy;

    escalonador_semaforo dut (
        .clk(clk), .rst(rst), .req(req), .bt(bt),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .luz(luz), .ped_luz(ped_luz), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a queue of upcoming phase cycles; empty queue means idle.
    localparam int K_IDLE = -1, K_GREEN = 0, K_YEL = 1, K_PED = 2, K_RED = 3;
    int          q[$];
    int          m_cfg[4];
    logic [3:0]  m_pend;
    logic        m_ped;
    int          m_grant;
    int          m_ext;
    logic [11:0] exp_luz;
    logic        exp_ped, exp_busy;
    bit          chk_en = 0;

    function automatic int dur(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic logic [11:0] lights(input int kind, input int g);
        logic [11:0] l;
        for (int i = 0; i < 4; i++) begin
            if (kind == K_GREEN && i == g)    l[3*i +: 3] = 3'b001;
            else if (kind == K_YEL && i == g) l[3*i +: 3] = 3'b010;
            else                              l[3*i +: 3] = 3'b100;
        end
        return l;
    endfunction

    task automatic push_n(input int kind, input int n);
        for (int i = 0; i < n; i++) q.push_back(kind);
    endtask

    always @(posedge clk) begin
        int cur, nxt;
        logic [3:0] clr;
        logic enter_ped;
        if (rst) begin
            q.delete();
            m_cfg[0] = 4; m_cfg[1] = 2; m_cfg[2] = 1; m_cfg[3] = 3;
            m_pend = 4'b0000; m_ped = 1'b0; m_grant = 3; m_ext = 0;
            chk_en = 1;
        end else begin
            cur = (q.size() > 0) ? q.pop_front() : K_IDLE;
            clr = 4'b0000;
            enter_ped = 1'b0;
            if (cur == K_IDLE) begin
                if (m_ped) begin
                    push_n(K_PED, dur(m_cfg[3]));
                    push_n(K_RED, dur(m_cfg[2]));
                    enter_ped = 1'b1;
                end else if (m_pend != 4'b0000) begin
                    for (int k = 1; k <= 4; k++) begin
                        if (clr == 4'b0000 && m_pend[(m_grant + k) % 4]) begin
                            m_grant = (m_grant + k) % 4;
                            clr[m_grant] = 1'b1;
                        end
                    end
                    m_ext = 0;
                    push_n(K_GREEN, dur(m_cfg[0]));
                    push_n(K_YEL, dur(m_cfg[1]));
                    push_n(K_RED, dur(m_cfg[2]));
                end
            end else if (cur == K_GREEN && q[0] != K_GREEN) begin
`ifdef GREEN_EXTEND_EN
                if (req[m_grant] && ((m_pend & ~(4'b0001 << m_grant)) == 4'b0000)
                    && !m_ped && m_ext < 2) begin
                    for (int i = 0; i < dur(m_cfg[0]); i++) q.push_front(K_GREEN);
                    m_ext++;
                end
`endif
            end
            if (enter_ped)        m_ped = 1'b0;
            else if (cur != K_PED) m_ped = m_ped | bt;
            m_pend = (m_pend & ~clr) | req;
            if (cfg_we) m_cfg[cfg_addr] = int'(cfg_data);
        end
        nxt = (q.size() > 0) ? q[0] : K_IDLE;
        exp_luz  = lights(nxt, m_grant);
        exp_ped  = (nxt == K_PED);
        exp_busy = (nxt != K_IDLE);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_luz", int'(luz), int'(exp_luz));
            check("cmp_ped_luz", int'(ped_luz), int'(exp_ped));
            check("cmp_busy", int'(busy), int'(exp_busy));
            check("cmp_grant", int'(grant), m_grant);
        end
    end

    task automatic expect_phase(input string nm, input logic [11:0] l, input logic p,
                                input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({nm, "_luz"}, int'(luz), int'(l));
            check({nm, "_ped"}, int'(ped_luz), int'(p));
            check({nm, "_busy"}, int'(busy), int'(b));
        end
        $display("[t=%0t] %s: %0d cycles luz=%03h", $time, nm, n, l);
    endtask

    task automatic wait_idle(input string nm);
        int quiet = 0;
        int cyc = 0;
        while (quiet < 2 && cyc < 150) begin
            @(negedge clk);
            cyc++;
            quiet = busy ? 0 : quiet + 1;
        end
        check({nm, "_idle_timeout"}, int'(quiet >= 2), 1);
    endtask

    initial begin
        // 1: reset and quiet idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("t1_luz", int'(luz), 12'h924);
        check("t1_ped", int'(ped_luz), 0);
        check("t1_grant", int'(grant), 3);
        check("t1_busy", int'(busy), 0);
        expect_phase("t1_hold", 12'h924, 1'b0, 1'b0, 5);

        // 2: single request from approach 2
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        check("t2_decide_luz", int'(luz), 12'h924);
        expect_phase("t2_green", 12'h864, 1'b0, 1'b1, 4);
        check("t2_grant", int'(grant), 2);
        expect_phase("t2_yellow", 12'h8A4, 1'b0, 1'b1, 2);
        expect_phase("t2_red", 12'h924, 1'b0, 1'b1, 1);
        expect_phase("t2_idle", 12'h924, 1'b0, 1'b0, 1);

        // 3: round robin over approaches 0 and 2, then 0 again before a repeat of 2
        req = 4'b0101;
        @(negedge clk);
        req = 4'b0000;
        expect_phase("t3_green0", 12'h921, 1'b0, 1'b1, 4);
        expect_phase("t3_yellow0", 12'h922, 1'b0, 1'b1, 2);
        expect_phase("t3_red0", 12'h924, 1'b0, 1'b1, 1);
        expect_phase("t3_idle", 12'h924, 1'b0, 1'b0, 1);
        expect_phase("t3_green2a", 12'h864, 1'b0, 1'b1, 1);
        req = 4'b0101;
        expect_phase("t3_green2b", 12'h864, 1'b0, 1'b1, 1);
        req = 4'b0000;
        expect_phase("t3_green2c", 12'h864, 1'b0, 1'b1, 2);
        expect_phase("t3_yellow2", 12'h8A4, 1'b0, 1'b1, 2);
        expect_phase("t3_red2", 12'h924, 1'b0, 1'b1, 1);
        expect_phase("t3_idle2", 12'h924, 1'b0, 1'b0, 1);
        expect_phase("t3_green0_again", 12'h921, 1'b0, 1'b1, 1);
        check("t3_grant", int'(grant), 0);
        wait_idle("t3");

        // 4: pedestrian and vehicle together; the walk goes first
        bt = 1'b1; req = 4'b0010;
        @(negedge clk);
        bt = 1'b0; req = 4'b0000;
        expect_phase("t4_ped", 12'h924, 1'b1, 1'b1, 3);
        expect_phase("t4_red", 12'h924, 1'b0, 1'b1, 1);
        expect_phase("t4_idle", 12'h924, 1'b0, 1'b0, 1);
        expect_phase("t4_green1", 12'h90C, 1'b0, 1'b1, 4);
        check("t4_grant", int'(grant), 1);
        wait_idle("t4");

        // 5: green duration rewritten to 0 mid-green
        req = 4'b1000;
        @(negedge clk);
        req = 4'b0000;
        expect_phase("t5_green3a", 12'h324, 1'b0, 1'b1, 1);
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd0;
        expect_phase("t5_green3b", 12'h324, 1'b0, 1'b1, 1);
        cfg_we = 1'b0;
        expect_phase("t5_green3c", 12'h324, 1'b0, 1'b1, 2);
        expect_phase("t5_yellow3", 12'h524, 1'b0, 1'b1, 2);
        wait_idle("t5a");
        req = 4'b1000;
        @(negedge clk);
        req = 4'b0000;
        expect_phase("t5_short_green", 12'h324, 1'b0, 1'b1, 1);
        expect_phase("t5_short_yellow", 12'h524, 1'b0, 1'b1, 2);
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd4;
        @(negedge clk);
        cfg_we = 1'b0;
        wait_idle("t5b");

        // 6: reset in the middle of yellow drops the pending request
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        expect_phase("t6_green0a", 12'h921, 1'b0, 1'b1, 1);
        req = 4'b0010;
        expect_phase("t6_green0b", 12'h921, 1'b0, 1'b1, 1);
        req = 4'b0000;
        expect_phase("t6_green0c", 12'h921, 1'b0, 1'b1, 2);
        expect_phase("t6_yellow0", 12'h922, 1'b0, 1'b1, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_luz", int'(luz), 12'h924);
        check("t6_rst_grant", int'(grant), 3);
        check("t6_rst_busy", int'(busy), 0);
        expect_phase("t6_after_rst", 12'h924, 1'b0, 1'b0, 4);

`ifdef GREEN_EXTEND_EN
        // Extension: approach 0 keeps requesting alone
        req = 4'b0001;
        @(negedge clk);
        expect_phase("t6_ext_green", 12'h921, 1'b0, 1'b1, 12);
        req = 4'b0000;
        expect_phase("t6_ext_yellow", 12'h922, 1'b0, 1'b1, 2);
        wait_idle("t6_ext");
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
